// File: rtl/rob_commit_if.sv
// rob_commit_if: decoder issue, result broadcast, operand lookup and retirement signals of the reorder buffer.
interface rob_commit_if #(
  parameter int ROB_BIT = 3
);

  logic               issue_signal;
  logic [4:0]         issue_rd;
  logic               issue_is_branch;
  logic               issue_pred_taken;
  logic [31:0]        issue_alt_pc;
  logic [ROB_BIT-1:0] rob_tail;
  logic               rob_full;

  logic               rs_ready;
  logic [ROB_BIT-1:0] rs_rob_entry;
  logic [31:0]        rs_value;
  logic               lsb_ready;
  logic [ROB_BIT-1:0] lsb_rob_entry;
  logic [31:0]        lsb_value;

  logic [ROB_BIT-1:0] query_entry1;
  logic [ROB_BIT-1:0] query_entry2;
  logic               query_ready1;
  logic               query_ready2;
  logic [31:0]        query_value1;
  logic [31:0]        query_value2;

  logic               commit_valid;
  logic [4:0]         commit_rd;
  logic [31:0]        commit_value;
  logic [ROB_BIT-1:0] commit_rob_entry;
  logic               rob_clear_up;
  logic [31:0]        clear_pc;

  modport master (
    output issue_signal, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    output rs_ready, rs_rob_entry, rs_value, lsb_ready, lsb_rob_entry, lsb_value,
    output query_entry1, query_entry2,
    input  rob_tail, rob_full, query_ready1, query_ready2, query_value1, query_value2,
    input  commit_valid, commit_rd, commit_value, commit_rob_entry, rob_clear_up, clear_pc
  );

  modport slave (
    input  issue_signal, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    input  rs_ready, rs_rob_entry, rs_value, lsb_ready, lsb_rob_entry, lsb_value,
    input  query_entry1, query_entry2,
    output rob_tail, rob_full, query_ready1, query_ready2, query_value1, query_value2,
    output commit_valid, commit_rd, commit_value, commit_rob_entry, rob_clear_up, clear_pc
  );

endinterface

// File: rtl/rob_commit.sv
// rob_commit: circular reorder buffer that allocates entries in order, collects results from the
// ALU and load/store broadcasts, retires the oldest finished entry each cycle and flushes on a
// mispredicted branch.
module rob_commit #(
  parameter int ROB_BIT = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  rob_commit_if.slave bus
);

  localparam int ROB_SIZE = 2 ** ROB_BIT;
  localparam logic [ROB_BIT:0] FULL_COUNT = {1'b1, {ROB_BIT{1'b0}}};

  logic [ROB_BIT-1:0] r_head;
  logic [ROB_BIT-1:0] r_tail;
  logic [ROB_BIT:0]   r_count;

  logic               r_busy     [ROB_SIZE];
  logic               r_ready    [ROB_SIZE];
  logic [4:0]         r_rd       [ROB_SIZE];
  logic [31:0]        r_value    [ROB_SIZE];
  logic               r_isBranch [ROB_SIZE];
  logic               r_pred     [ROB_SIZE];
  logic [31:0]        r_altPc    [ROB_SIZE];

  logic               r_commitValid;
  logic [4:0]         r_commitRd;
  logic [31:0]        r_commitValue;
  logic [ROB_BIT-1:0] r_commitEntry;
  logic               r_clearUp;
  logic [31:0]        r_clearPc;

  logic w_full;
  logic w_issueAccept;
  logic w_commitFire;
  logic w_mispredict;
  logic w_rsWrite;
  logic w_lsbWrite;

  assign bus.rob_tail         = r_tail;
  assign bus.rob_full         = w_full;
  assign bus.commit_valid     = r_commitValid;
  assign bus.commit_rd        = r_commitRd;
  assign bus.commit_value     = r_commitValue;
  assign bus.commit_rob_entry = r_commitEntry;
  assign bus.rob_clear_up     = r_clearUp;
  assign bus.clear_pc         = r_clearPc;

  // Per-cycle decisions; the cycle after a flush ignores issue and writeback, rs beats lsb on the same entry.
  always_comb begin
    w_full        = (r_count == FULL_COUNT);
    w_issueAccept = bus.issue_signal && !w_full && !r_clearUp;
    w_commitFire  = r_busy[r_head] && r_ready[r_head];
    w_mispredict  = w_commitFire && r_isBranch[r_head] && (r_value[r_head][0] != r_pred[r_head]);
    w_rsWrite     = bus.rs_ready && r_busy[bus.rs_rob_entry] && !r_clearUp;
    w_lsbWrite    = bus.lsb_ready && r_busy[bus.lsb_rob_entry] && !r_clearUp
                    && !(bus.rs_ready && (bus.rs_rob_entry == bus.lsb_rob_entry));
  end

  // Operand lookup: stored result first, then same-cycle rs broadcast, then lsb broadcast.
  always_comb begin
    bus.query_ready1 = 1'b0;
    bus.query_value1 = '0;
    bus.query_ready2 = 1'b0;
    bus.query_value2 = '0;
    if (r_ready[bus.query_entry1]) begin
      bus.query_ready1 = 1'b1;
      bus.query_value1 = r_value[bus.query_entry1];
    end else if (bus.rs_ready && (bus.rs_rob_entry == bus.query_entry1)) begin
      bus.query_ready1 = 1'b1;
      bus.query_value1 = bus.rs_value;
    end else if (bus.lsb_ready && (bus.lsb_rob_entry == bus.query_entry1)) begin
      bus.query_ready1 = 1'b1;
      bus.query_value1 = bus.lsb_value;
    end
    if (r_ready[bus.query_entry2]) begin
      bus.query_ready2 = 1'b1;
      bus.query_value2 = r_value[bus.query_entry2];
    end else if (bus.rs_ready && (bus.rs_rob_entry == bus.query_entry2)) begin
      bus.query_ready2 = 1'b1;
      bus.query_value2 = bus.rs_value;
    end else if (bus.lsb_ready && (bus.lsb_rob_entry == bus.query_entry2)) begin
      bus.query_ready2 = 1'b1;
      bus.query_value2 = bus.lsb_value;
    end
  end

  // Entry storage and pointers; a mispredict flush overrides everything else on its edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_busy[i]     <= 1'b0;
        r_ready[i]    <= 1'b0;
        r_rd[i]       <= '0;
        r_value[i]    <= '0;
        r_isBranch[i] <= 1'b0;
        r_pred[i]     <= 1'b0;
        r_altPc[i]    <= '0;
      end
    end else if (rdy_in) begin
      if (w_rsWrite) begin
        r_value[bus.rs_rob_entry] <= bus.rs_value;
        r_ready[bus.rs_rob_entry] <= 1'b1;
      end
      if (w_lsbWrite) begin
        r_value[bus.lsb_rob_entry] <= bus.lsb_value;
        r_ready[bus.lsb_rob_entry] <= 1'b1;
      end
      if (w_issueAccept) begin
        r_busy[r_tail]     <= 1'b1;
        r_ready[r_tail]    <= 1'b0;
        r_rd[r_tail]       <= bus.issue_rd;
        r_isBranch[r_tail] <= bus.issue_is_branch;
        r_pred[r_tail]     <= bus.issue_pred_taken;
        r_altPc[r_tail]    <= bus.issue_alt_pc;
        r_tail             <= r_tail + 1'b1;
      end
      if (w_commitFire) begin
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_issueAccept && !w_commitFire) begin
        r_count <= r_count + 1'b1;
      end else if (!w_issueAccept && w_commitFire) begin
        r_count <= r_count - 1'b1;
      end
      if (w_mispredict) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end
      end
    end
  end

  // Registered retirement port and flush request; both pulse for one ready cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_commitValid <= 1'b0;
      r_commitRd    <= '0;
      r_commitValue <= '0;
      r_commitEntry <= '0;
      r_clearUp     <= 1'b0;
      r_clearPc     <= '0;
    end else if (rdy_in) begin
      r_commitValid <= w_commitFire;
      r_clearUp     <= w_mispredict;
      if (w_commitFire) begin
        r_commitRd    <= r_isBranch[r_head] ? 5'd0 : r_rd[r_head];
        r_commitValue <= r_value[r_head];
        r_commitEntry <= r_head;
      end
      if (w_mispredict) begin
        r_clearPc <= r_altPc[r_head];
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed scenarios plus randomized traffic against an entry-list model of the reorder buffer.
module tb_rob_commit;

  localparam int ROB_BIT  = 3;
  localparam int ROB_SIZE = 1 << ROB_BIT;

  logic clkIn;
  logic rstIn;
  logic rdyIn;

  int testsRun;
  int testsFailed;

  // Reference model: one record per slot plus oldest/next indices and occupancy.
  bit          mBusy [ROB_SIZE];
  bit          mDone [ROB_SIZE];
  logic [4:0]  mRd   [ROB_SIZE];
  logic [31:0] mVal  [ROB_SIZE];
  logic [31:0] mAlt  [ROB_SIZE];
  bit          mBr   [ROB_SIZE];
  bit          mPred [ROB_SIZE];
  int          mHead;
  int          mTail;
  int          mCount;

  bit          eValid;
  bit          eClear;
  logic [4:0]  eRd;
  logic [31:0] eValue;
  logic [31:0] eClearPc;
  int          eEntry;

  rob_commit_if #(.ROB_BIT(ROB_BIT)) bus ();

  rob_commit #(.ROB_BIT(ROB_BIT)) dut (
    .clk_in (clkIn),
    .rst_in (rstIn),
    .rdy_in (rdyIn),
    .bus    (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < ROB_SIZE; i++) begin
      mBusy[i] = 1'b0;
      mDone[i] = 1'b0;
    end
    mHead = 0; mTail = 0; mCount = 0;
    eValid = 1'b0; eClear = 1'b0; eRd = '0; eValue = '0; eClearPc = '0; eEntry = 0;
  endtask

  task automatic clearInputs();
    rdyIn = 1'b1;
    bus.issue_signal = 1'b0; bus.issue_rd = '0; bus.issue_is_branch = 1'b0;
    bus.issue_pred_taken = 1'b0; bus.issue_alt_pc = '0;
    bus.rs_ready = 1'b0; bus.rs_rob_entry = '0; bus.rs_value = '0;
    bus.lsb_ready = 1'b0; bus.lsb_rob_entry = '0; bus.lsb_value = '0;
    bus.query_entry1 = '0; bus.query_entry2 = '1;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic modelEdge();
    bit blocked;
    bit doCommit;
    int h;
    int rsE;
    int lsbE;
    if (!rdyIn) return;
    blocked  = eClear;
    h        = mHead;
    doCommit = mBusy[h] && mDone[h];
    eValid   = doCommit;
    eClear   = 1'b0;
    if (doCommit) begin
      eRd    = mBr[h] ? 5'd0 : mRd[h];
      eValue = mVal[h];
      eEntry = h;
      if (mBr[h] && (mVal[h][0] != mPred[h])) begin
        eClear   = 1'b1;
        eClearPc = mAlt[h];
      end
    end
    rsE  = int'(bus.rs_rob_entry);
    lsbE = int'(bus.lsb_rob_entry);
    if (!blocked) begin
      if (bus.rs_ready && mBusy[rsE]) begin
        mVal[rsE] = bus.rs_value; mDone[rsE] = 1'b1;
      end
      if (bus.lsb_ready && mBusy[lsbE] && !(bus.rs_ready && rsE == lsbE)) begin
        mVal[lsbE] = bus.lsb_value; mDone[lsbE] = 1'b1;
      end
      if (bus.issue_signal && mCount < ROB_SIZE) begin
        mBusy[mTail] = 1'b1; mDone[mTail] = 1'b0; mRd[mTail] = bus.issue_rd;
        mBr[mTail] = bus.issue_is_branch; mPred[mTail] = bus.issue_pred_taken;
        mAlt[mTail] = bus.issue_alt_pc;
        mTail = (mTail + 1) % ROB_SIZE;
        mCount++;
      end
    end
    if (doCommit) begin
      mBusy[h] = 1'b0; mDone[h] = 1'b0;
      mHead = (mHead + 1) % ROB_SIZE;
      mCount--;
    end
    if (eClear) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        mBusy[i] = 1'b0; mDone[i] = 1'b0;
      end
      mHead = 0; mTail = 0; mCount = 0;
    end
  endtask

  task automatic checkQuery(input string tag, input logic [ROB_BIT-1:0] q, input logic r, input logic [31:0] v);
    bit          er;
    logic [31:0] ev;
    er = 1'b0; ev = '0;
    if (mBusy[q] && mDone[q]) begin
      er = 1'b1; ev = mVal[q];
    end else if (bus.rs_ready && bus.rs_rob_entry == q) begin
      er = 1'b1; ev = bus.rs_value;
    end else if (bus.lsb_ready && bus.lsb_rob_entry == q) begin
      er = 1'b1; ev = bus.lsb_value;
    end
    checkOutput({tag, "_ready"}, 32'(r), 32'(er));
    checkOutput({tag, "_value"}, v, ev);
  endtask

  task automatic checkComb();
    checkOutput("rob_tail", 32'(bus.rob_tail), 32'(mTail));
    checkOutput("rob_full", 32'(bus.rob_full), 32'(mCount == ROB_SIZE));
    checkQuery("query1", bus.query_entry1, bus.query_ready1, bus.query_value1);
    checkQuery("query2", bus.query_entry2, bus.query_ready2, bus.query_value2);
  endtask

  task automatic checkRegs();
    checkOutput("commit_valid", 32'(bus.commit_valid), 32'(eValid));
    if (eValid) begin
      checkOutput("commit_rd", 32'(bus.commit_rd), 32'(eRd));
      checkOutput("commit_value", bus.commit_value, eValue);
      checkOutput("commit_rob_entry", 32'(bus.commit_rob_entry), 32'(eEntry));
    end
    checkOutput("rob_clear_up", 32'(bus.rob_clear_up), 32'(eClear));
    if (eClear) checkOutput("clear_pc", bus.clear_pc, eClearPc);
  endtask

  // One clock: starts 1 time unit after a rising edge with inputs already driven.
  task automatic runCycle();
    #2;
    checkComb();
    modelEdge();
    @(posedge clkIn);
    #1;
    checkRegs();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any edge arrives.
  task automatic doReset();
    rstIn = 1'b0;
    #1;
    checkOutput("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    checkOutput("rst_commit_rd", 32'(bus.commit_rd), 32'd0);
    checkOutput("rst_commit_value", bus.commit_value, 32'd0);
    checkOutput("rst_commit_entry", 32'(bus.commit_rob_entry), 32'd0);
    checkOutput("rst_clear_up", 32'(bus.rob_clear_up), 32'd0);
    checkOutput("rst_clear_pc", bus.clear_pc, 32'd0);
    checkOutput("rst_rob_full", 32'(bus.rob_full), 32'd0);
    checkOutput("rst_rob_tail", 32'(bus.rob_tail), 32'd0);
    modelReset();
    @(posedge clkIn);
    #1;
    rstIn = 1'b1;
    clearInputs();
  endtask

  task automatic issueOne(input logic [4:0] rd);
    clearInputs();
    bus.issue_signal = 1'b1;
    bus.issue_rd = rd;
    runCycle();
  endtask

  task automatic writeRs(input int entry, input logic [31:0] value);
    clearInputs();
    bus.rs_ready = 1'b1;
    bus.rs_rob_entry = ROB_BIT'(entry);
    bus.rs_value = value;
    runCycle();
  endtask

  task automatic idleCycle();
    clearInputs();
    runCycle();
  endtask

  // Random traffic biased toward occupied entries so results and commits happen often.
  task automatic applyStimulus();
    int span;
    span = (mCount > 0) ? mCount : 1;
    rdyIn = ($urandom_range(0, 7) != 0);
    bus.issue_signal     = $urandom_range(0, 1) == 1;
    bus.issue_rd         = 5'($urandom);
    bus.issue_is_branch  = ($urandom_range(0, 4) == 0);
    bus.issue_pred_taken = $urandom_range(0, 1) == 1;
    bus.issue_alt_pc     = $urandom;
    bus.rs_ready         = $urandom_range(0, 1) == 1;
    bus.rs_rob_entry     = ($urandom_range(0, 3) == 0) ? ROB_BIT'($urandom)
                                                       : ROB_BIT'(mHead + int'($urandom_range(0, span - 1)));
    bus.rs_value         = $urandom;
    bus.lsb_ready        = $urandom_range(0, 1) == 1;
    bus.lsb_rob_entry    = ($urandom_range(0, 4) == 0) ? bus.rs_rob_entry
                                                       : ROB_BIT'(mHead + int'($urandom_range(0, span - 1)));
    bus.lsb_value        = $urandom;
    bus.query_entry1     = ROB_BIT'($urandom);
    bus.query_entry2     = ROB_BIT'($urandom);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rstIn = 1'b1;
    clearInputs();
    modelReset();
    #3;
    doReset();

    // Single result retires two edges after its writeback.
    issueOne(5'd5);
    writeRs(0, 32'h2A);
    idleCycle();
    checkOutput("req030_valid", 32'(bus.commit_valid), 32'd1);
    checkOutput("req030_rd", 32'(bus.commit_rd), 32'd5);
    checkOutput("req030_value", bus.commit_value, 32'h2A);

    // Fill all slots, reject the extra issue, then wrap after one retirement.
    doReset();
    for (int i = 0; i < ROB_SIZE; i++) issueOne(5'(i + 1));
    checkOutput("req031_full", 32'(bus.rob_full), 32'd1);
    issueOne(5'd31);
    checkOutput("req031_tail", 32'(bus.rob_tail), 32'd0);
    checkOutput("req031_still_full", 32'(bus.rob_full), 32'd1);
    writeRs(0, 32'h7);
    idleCycle();
    checkOutput("req031_not_full", 32'(bus.rob_full), 32'd0);
    issueOne(5'd9);
    checkOutput("req031_wrap_tail", 32'(bus.rob_tail), 32'd1);
    checkOutput("req031_refull", 32'(bus.rob_full), 32'd1);

    // Out-of-order completion still retires in order on consecutive cycles.
    doReset();
    issueOne(5'd3);
    issueOne(5'd4);
    writeRs(1, 32'hB1);
    idleCycle();
    checkOutput("req032_hold", 32'(bus.commit_valid), 32'd0);
    writeRs(0, 32'hB0);
    idleCycle();
    checkOutput("req032_first", 32'(bus.commit_rob_entry), 32'd0);
    idleCycle();
    checkOutput("req032_second_valid", 32'(bus.commit_valid), 32'd1);
    checkOutput("req032_second", 32'(bus.commit_rob_entry), 32'd1);
    idleCycle();

    // Mispredicted branch flushes and redirects; the flush cycle ignores a new issue.
    doReset();
    clearInputs();
    bus.issue_signal = 1'b1; bus.issue_rd = 5'd9; bus.issue_is_branch = 1'b1;
    bus.issue_pred_taken = 1'b1; bus.issue_alt_pc = 32'h100;
    runCycle();
    issueOne(5'd2);
    writeRs(0, 32'h0);
    idleCycle();
    checkOutput("req033_clear", 32'(bus.rob_clear_up), 32'd1);
    checkOutput("req033_pc", bus.clear_pc, 32'h100);
    checkOutput("req033_rd", 32'(bus.commit_rd), 32'd0);
    checkOutput("req033_tail", 32'(bus.rob_tail), 32'd0);
    issueOne(5'd6);
    checkOutput("req033_clear_drop", 32'(bus.rob_clear_up), 32'd0);
    checkOutput("req033_ignored", 32'(bus.rob_tail), 32'd0);
    issueOne(5'd6);
    checkOutput("req033_landed", 32'(bus.rob_tail), 32'd1);

    // Both broadcasts on one entry: rs value is stored and forwarded.
    doReset();
    for (int i = 0; i < 3; i++) issueOne(5'(i + 10));
    clearInputs();
    bus.rs_ready = 1'b1;  bus.rs_rob_entry = 3'd2;  bus.rs_value = 32'h11;
    bus.lsb_ready = 1'b1; bus.lsb_rob_entry = 3'd2; bus.lsb_value = 32'h22;
    bus.query_entry1 = 3'd2;
    #1;
    checkOutput("req034_fwd_ready", 32'(bus.query_ready1), 32'd1);
    checkOutput("req034_fwd_value", bus.query_value1, 32'h11);
    runCycle();
    clearInputs();
    bus.query_entry1 = 3'd2;
    #1;
    checkOutput("req034_stored", bus.query_value1, 32'h11);
    runCycle();

    // Reset lands while a retirement is being reported with four entries in flight.
    doReset();
    for (int i = 0; i < 4; i++) issueOne(5'(i + 20));
    writeRs(0, 32'h55);
    idleCycle();
    checkOutput("req035_mid_commit", 32'(bus.commit_valid), 32'd1);
    doReset();
    checkOutput("req035_tail", 32'(bus.rob_tail), 32'd0);
    issueOne(5'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus();
      runCycle();
      if (i % 500 == 499) doReset();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 Parameter ROB_BIT, default 3, sets entry index width; ROB_SIZE = 2**ROB_BIT (default 8).
REQ-002 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  ready; when low, all state and outputs hold.
REQ-005 issue_signal  input  1  allocate one entry this cycle (from decoder).
REQ-006 issue_rd  input  5  destination register.
REQ-007 issue_is_branch  input  1  entry is a conditional branch.
REQ-008 issue_pred_taken  input  1  predicted direction.
REQ-009 issue_alt_pc  input  32  redirect PC if prediction wrong.
REQ-010 rob_tail  output  ROB_BIT  entry index the next issue receives (decoder uses it as rd_rob).
REQ-011 rob_full  output  1  all entries occupied.
REQ-012 rs_ready, rs_rob_entry[ROB_BIT], rs_value[32]  input  ALU result broadcast.
REQ-013 lsb_ready, lsb_rob_entry[ROB_BIT], lsb_value[32]  input  load/store result broadcast.
REQ-014 query_entry1/query_entry2  input  ROB_BIT  operand producer lookups.
REQ-015 query_ready1/query_ready2  output  1; query_value1/query_value2  output  32  lookup results.
REQ-016 commit_valid  output  1; commit_rd  output  5; commit_value  output  32; commit_rob_entry  output  ROB_BIT  registered retirement port.
REQ-017 rob_clear_up  output  1; clear_pc  output  32  misprediction flush and redirect.

Function
REQ-018 Circular buffer: head, tail pointers, count 0..ROB_SIZE; rob_full = (count == ROB_SIZE); rob_tail = tail.
REQ-019 Issue accepted when issue_signal && !rob_full: entry[tail] busy=1, ready=0, fields captured; tail wraps ROB_SIZE-1 -> 0. Issue while full is ignored, no state change.
REQ-020 Writeback: each of rs/lsb with valid set and target entry busy writes value, ready=1. Both ports to distinct entries in one cycle: both recorded. Same entry: rs value wins. Writeback to non-busy entry ignored.
REQ-021 Commit: when entry[head] busy && ready, at the edge: commit_valid=1 next cycle with its rd/value/index, busy cleared, head advances (wraps). At most one commit per cycle; commit_valid is a single-cycle pulse otherwise 0.
REQ-022 Earliest commit: edge after the writeback edge (writeback-to-commit_valid = 2 edges).
REQ-023 Branch commit: commit_rd forced 0; if value[0] != pred_taken: rob_clear_up=1 and clear_pc=alt_pc for one cycle, all busy cleared, head=tail=count=0 that edge; correct prediction retires normally with no flush.
REQ-024 While rob_clear_up=1, issue and writeback in that cycle are ignored.
REQ-025 Simultaneous issue and commit: count unchanged; rob_full evaluated on registered count, so issue while full is rejected even if a commit occurs that cycle.
REQ-026 Query: combinational; ready=1 with value if entry ready, else if the same-cycle rs (priority) or lsb broadcast targets that entry, forward that value; otherwise ready=0, value=0.
REQ-027 rdy_in low: no issue, writeback, commit or flush; commit_valid and rob_clear_up hold their previous values.

Reset
REQ-028 rst_in low (any time, mid-operation included): head=tail=count=0, all busy/ready=0, rob_full=0, commit_valid=0, commit_rd=0, commit_value=0, commit_rob_entry=0, rob_clear_up=0, clear_pc=0, immediately and asynchronously.
REQ-029 First issue after rst_in release receives entry 0.

Verification
REQ-030 Issue rd=5 (entry 0), rs writeback entry0 value 0x2A next cycle -> commit_valid=1, commit_rd=5, commit_value=0x2A two edges later.
REQ-031 Issue 8 entries -> rob_full=1, 9th issue ignored, rob_tail=0; one commit -> rob_full=0, next issue lands at entry 0 (wrap).
REQ-032 Entries 0,1 issued; writeback entry1 before entry0 -> no commit until entry0 ready, then commits 0 then 1 on consecutive cycles.
REQ-033 Branch entry, pred_taken=1, writeback value 0, alt_pc 0x100 -> rob_clear_up=1, clear_pc=0x100 one cycle, count=0, next issue at entry 0.
REQ-034 rs and lsb both write entry 2 with 0x11/0x22 same cycle -> stored 0x22? no: stored 0x11; query_entry1=2 that cycle returns ready=1, value 0x11.
REQ-035 rst_in pulsed low mid-commit with 4 entries busy -> all outputs zero asynchronously, rob_tail=0 after release.
